idecoder_pipe: RTL



---
 rtl/idecoder_pipe.sv | 315 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/idecoder_pipe.sv
// Buffered RV32I(+M) instruction decode stage: input FIFO, combinational decode
// of the FIFO head, and a registered output stage with valid/ready handshake.

package idecoder_pkg;
  localparam int INST_WIDTH      = 32;
  localparam int IMM_WIDTH       = 32;
  localparam int REG_WIDTH       = 5;
  localparam int INST_TYPE_WIDTH = 4;
  localparam int FUNCT_WIDTH     = 5;

  // Instruction classes; 0 is reserved for illegal encodings.
  localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_NONE    = 4'd0;
  localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_IMM     = 4'd1;  // LUI
  localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_INT_IMM = 4'd2;
  localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_INT_REG = 4'd3;
  localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_BRANCH  = 4'd4;
  localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_JAL     = 4'd5;
  localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_JALR    = 4'd6;
  localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_LOAD    = 4'd7;
  localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_STORE   = 4'd8;
  localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_AUIPC   = 4'd9;
  localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_FENCE   = 4'd10;

  // Operation codes; the M group is contiguous so funct3 can be added to FUNCT_MUL.
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_NONE      = 5'd0;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_ADD       = 5'd1;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_SUB       = 5'd2;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_SLT       = 5'd3;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_SLTU      = 5'd4;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_XOR       = 5'd5;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_OR        = 5'd6;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_AND       = 5'd7;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_SLL       = 5'd8;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_SRL       = 5'd9;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_SRA       = 5'd10;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_EQ        = 5'd11;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_NEQ       = 5'd12;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_LT        = 5'd13;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_GE        = 5'd14;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_LTU       = 5'd15;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_GEU       = 5'd16;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_MEM_BYTE  = 5'd17;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_MEM_HWORD = 5'd18;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_MEM_WORD  = 5'd19;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_MEM_BYTEU = 5'd20;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_MEM_HWORDU= 5'd21;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_MUL       = 5'd22;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_MULH      = 5'd23;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_MULHSU    = 5'd24;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_MULHU     = 5'd25;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_DIV       = 5'd26;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_DIVU      = 5'd27;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_REM       = 5'd28;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_REMU      = 5'd29;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  typedef struct packed {
    logic [INST_TYPE_WIDTH-1:0] inst_type;
    logic [FUNCT_WIDTH-1:0]     funct;
    logic [IMM_WIDTH-1:0]       imm;
    logic [REG_WIDTH-1:0]       rd;
    logic [REG_WIDTH-1:0]       rs1;
    logic [REG_WIDTH-1:0]       rs2;
    logic                       illegal;
  } dec_t;
endpackage

module idecoder_pipe
  import idecoder_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int ENABLE_M = 0,
  parameter int PC_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [INST_WIDTH-1:0]      inst,
  input  logic [PC_WIDTH-1:0]        inst_pc,
  input  logic                       inst_valid,
  output logic                       inst_ready,
  output logic                       dec_valid,
  input  logic                       dec_ready,
  output logic [PC_WIDTH-1:0]        dec_pc,
  output logic [IMM_WIDTH-1:0]       imm,
  output logic [INST_TYPE_WIDTH-1:0] inst_type,
  output logic [REG_WIDTH-1:0]       rd,
  output logic [REG_WIDTH-1:0]       rs1,
  output logic [REG_WIDTH-1:0]       rs2,
  output logic [FUNCT_WIDTH-1:0]     funct,
  output logic                       illegal
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [INST_WIDTH-1:0] mem_inst [DEPTH];
  logic [PC_WIDTH-1:0]   mem_pc   [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  push, pop;
  logic [INST_WIDTH-1:0] head;
  dec_t                  dec;

  assign inst_ready = (count != CNT_W'(DEPTH));
  assign push       = inst_valid && inst_ready;
  assign pop        = (count != '0) && (!dec_valid || dec_ready);
  assign head       = mem_inst[rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // FIFO storage write.
  // NOTE: the storage array has no reset; count/pointers alone define validity, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_inst[wr_ptr] <= inst;
      mem_pc[wr_ptr]   <= inst_pc;
    end
  end

  // FIFO pointers and occupancy; reset beats flush beats push/pop.
  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Combinational decode of the FIFO head; any unsupported encoding collapses to zeros + illegal.
  // NOTE: every field gets a default before the case so no path can infer a latch.
  always_comb begin
    logic [2:0] f3;
    logic [6:0] f7;
    logic       ok;
    f3  = head[14:12];
    f7  = head[31:25];
    ok  = 1'b0;
    dec = '0;
    case (head[6:0])
      OP_LUI, OP_AUIPC: begin
        dec.inst_type = (head[6:0] == OP_LUI) ? INST_TYPE_IMM : INST_TYPE_AUIPC;
        dec.rd        = head[11:7];
        dec.imm       = {head[31:12], 12'b0};
        ok            = 1'b1;
      end
      OP_JAL: begin
        dec.inst_type = INST_TYPE_JAL;
        dec.rd        = head[11:7];
        dec.imm       = {{12{head[31]}}, head[19:12], head[20], head[30:21], 1'b0};
        ok            = 1'b1;
      end
      OP_JALR: begin
        dec.inst_type = INST_TYPE_JALR;
        dec.rd        = head[11:7];
        dec.rs1       = head[19:15];
        dec.imm       = {{20{head[31]}}, head[31:20]};
        ok            = (f3 == 3'd0);
      end
      OP_BRANCH: begin
        dec.inst_type = INST_TYPE_BRANCH;
        dec.rs1       = head[19:15];
        dec.rs2       = head[24:20];
        dec.imm       = {{20{head[31]}}, head[7], head[30:25], head[11:8], 1'b0};
        ok            = 1'b1;
        case (f3)
          3'd0:    dec.funct = FUNCT_EQ;
          3'd1:    dec.funct = FUNCT_NEQ;
          3'd4:    dec.funct = FUNCT_LT;
          3'd5:    dec.funct = FUNCT_GE;
          3'd6:    dec.funct = FUNCT_LTU;
          3'd7:    dec.funct = FUNCT_GEU;
          default: ok = 1'b0;
        endcase
      end
      OP_LOAD: begin
        dec.inst_type = INST_TYPE_LOAD;
        dec.rd        = head[11:7];
        dec.rs1       = head[19:15];
        dec.imm       = {{20{head[31]}}, head[31:20]};
        ok            = 1'b1;
        case (f3)
          3'd0:    dec.funct = FUNCT_MEM_BYTE;
          3'd1:    dec.funct = FUNCT_MEM_HWORD;
          3'd2:    dec.funct = FUNCT_MEM_WORD;
          3'd4:    dec.funct = FUNCT_MEM_BYTEU;
          3'd5:    dec.funct = FUNCT_MEM_HWORDU;
          default: ok = 1'b0;
        endcase
      end
      OP_STORE: begin
        dec.inst_type = INST_TYPE_STORE;
        dec.rs1       = head[19:15];
        dec.rs2       = head[24:20];
        dec.imm       = {{20{head[31]}}, head[31:25], head[11:7]};
        ok            = 1'b1;
        case (f3)
          3'd0:    dec.funct = FUNCT_MEM_BYTE;
          3'd1:    dec.funct = FUNCT_MEM_HWORD;
          3'd2:    dec.funct = FUNCT_MEM_WORD;
          default: ok = 1'b0;
        endcase
      end
      OP_IMM: begin
        dec.inst_type = INST_TYPE_INT_IMM;
        dec.rd        = head[11:7];
        dec.rs1       = head[19:15];
        dec.imm       = {{20{head[31]}}, head[31:20]};
        ok            = 1'b1;
        case (f3)
          3'd0: dec.funct = FUNCT_ADD;
          3'd2: dec.funct = FUNCT_SLT;
          3'd3: dec.funct = FUNCT_SLTU;
          3'd4: dec.funct = FUNCT_XOR;
          3'd6: dec.funct = FUNCT_OR;
          3'd7: dec.funct = FUNCT_AND;
          3'd1: begin
            dec.imm   = {27'b0, head[24:20]};
            dec.funct = FUNCT_SLL;
            ok        = (f7 == 7'h00);
          end
          default: begin
            dec.imm   = {27'b0, head[24:20]};
            dec.funct = (f7 == 7'h20) ? FUNCT_SRA : FUNCT_SRL;
            ok        = (f7 == 7'h00) || (f7 == 7'h20);
          end
        endcase
      end
      OP_REG: begin
        dec.inst_type = INST_TYPE_INT_REG;
        dec.rd        = head[11:7];
        dec.rs1       = head[19:15];
        dec.rs2       = head[24:20];
        ok            = 1'b1;
        if (f7 == 7'h00) begin
          case (f3)
            3'd0: dec.funct = FUNCT_ADD;
            3'd1: dec.funct = FUNCT_SLL;
            3'd2: dec.funct = FUNCT_SLT;
            3'd3: dec.funct = FUNCT_SLTU;
            3'd4: dec.funct = FUNCT_XOR;
            3'd5: dec.funct = FUNCT_SRL;
            3'd6: dec.funct = FUNCT_OR;
            default: dec.funct = FUNCT_AND;
          endcase
        end else if (f7 == 7'h20 && f3 == 3'd0) begin
          dec.funct = FUNCT_SUB;
        end else if (f7 == 7'h20 && f3 == 3'd5) begin
          dec.funct = FUNCT_SRA;
        end else if (f7 == 7'h01 && ENABLE_M != 0) begin
          dec.funct = FUNCT_MUL + FUNCT_WIDTH'(f3);
        end else begin
          ok = 1'b0;
        end
      end
      OP_FENCE: begin
        dec.inst_type = INST_TYPE_FENCE;
        ok            = 1'b1;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  // Output register: loads the decoded head when empty or being drained, holds under backpressure.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dec_valid <= 1'b0;
      dec_pc    <= '0;
      inst_type <= '0;
      funct     <= '0;
      imm       <= '0;
      rd        <= '0;
      rs1       <= '0;
      rs2       <= '0;
      illegal   <= 1'b0;
    end else if (flush) begin
      dec_valid <= 1'b0;
    end else if (pop) begin
      dec_valid <= 1'b1;
      dec_pc    <= mem_pc[rd_ptr];
      inst_type <= dec.inst_type;
      funct     <= dec.funct;
      imm       <= dec.imm;
      rd        <= dec.rd;
      rs1       <= dec.rs1;
      rs2       <= dec.rs2;
      illegal   <= dec.illegal;
    end else if (dec_ready) begin
      dec_valid <= 1'b0;
    end
  end

endmodule
